l1_axi_arbiter_bridge: RTL
==========================

Name: l1_axi_arbiter_bridge

Overview:
- Parametrised successor to the single-port L1-to-AXI path.
- Arbitrates NUM_PORTS L1 request channels (round-robin) onto one AXI4 master port.
- Issues INCR read bursts of up to MAX_BURST beats and single-beat writes with byte strobes; returns read data to the granted port.
- Flags AXI error responses per port. Sits between the L1 caches/uncached units and the system interconnect; one transaction outstanding.

Parameters:
NUM_PORTS, 2, number of L1 requesters (1..8)
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width (32 only; assertion otherwise)
MAX_BURST, 16, max read beats per request (power of two, <=256)
ID_W, 6, AXI ID width; must satisfy ID_W >= clog2(NUM_PORTS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_request  in  NUM_PORTS  per-port request valid
req_addr  in  NUM_PORTS*ADDR_W  byte address (bits [1:0] ignored)
req_data  in  NUM_PORTS*DATA_W  write data
req_rnw  in  NUM_PORTS  1=read, 0=write
req_be  in  NUM_PORTS*4  write byte enables
req_size  in  NUM_PORTS*5  read beats minus 1
req_ack  out  NUM_PORTS  one-cycle accept pulse
ret_data  out  DATA_W  read beat data (shared)
ret_data_valid  out  NUM_PORTS  read beat valid for owning port
bus_error  out  NUM_PORTS  one-cycle pulse on SLVERR/DECERR
m_arvalid  out  1  AXI read address valid
m_arready  in  1  AXI read address ready
m_araddr  out  ADDR_W  read address, word aligned
m_arlen  out  8  beats minus 1
m_arid  out  ID_W  granted port index
m_rvalid  in  1  read data valid
m_rready  out  1  read data ready
m_rdata  in  DATA_W  read data
m_rresp  in  2  read response
m_rlast  in  1  last read beat
m_awvalid  out  1  write address valid
m_awready  in  1  write address ready
m_awaddr  out  ADDR_W  write address, word aligned
m_awid  out  ID_W  granted port index
m_wvalid  out  1  write data valid
m_wready  in  1  write data ready
m_wdata  out  DATA_W  write data
m_wstrb  out  DATA_W/8  write strobes = req_be
m_wlast  out  1  constant 1 while m_wvalid
m_bvalid  in  1  write response valid
m_bready  out  1  write response ready
m_bresp  in  2  write response

Behaviour:
- arsize=2, arburst=INCR, awlen=0, cache/prot/lock tied in the integration wrapper.
- Reset: state IDLE, RR pointer 0; all m_*valid, m_rready, m_bready, req_ack, ret_data_valid, bus_error = 0. Address/ID/data regs = 0.
- Reset mid-transaction abandons it; the interconnect is reset in the same domain.
- FSM: IDLE, AR, R, WR, B.
- IDLE: if any req_request, grant first asserted port at or after the RR pointer (wrapping). Latch addr/data/be/size/rnw and index g. Pulse req_ack[g] in the same cycle. Next state AR (read) or WR (write). No grant decision is made in any other state.
- Requester holds its fields stable until it sees req_ack. It may keep req_request high for back-to-back requests; a new grant is possible no earlier than the cycle after return to IDLE.
- AR: m_arvalid=1, m_arlen=min(size, MAX_BURST-1). On arvalid&arready go to R. arvalid never drops before ready.
- R: m_rready=1. ret_data=m_rdata; ret_data_valid[g]=m_rvalid (combinational, zero latency).
  - A nonzero rresp on any beat sets a sticky error flag.
  - On rvalid&rlast: go to IDLE. If error flag, pulse bus_error[g] the following cycle. Clear flag.
- WR: m_awvalid and m_wvalid both asserted from entry. Each drops independently on its own handshake; both may complete in the same cycle. When both are done, go to B.
- B: m_bready=1. On bvalid go to IDLE. If bresp != 0, pulse bus_error[g] the next cycle.
- RR pointer = g+1 mod NUM_PORTS, updated on return to IDLE.
- Minimum occupancy: read = 1 (IDLE) + 1 (AR) + beats; write = IDLE + WR + B, i.e. 3 cycles with zero-wait slave.
- Bursts crossing 4 KB are requester responsibility; a simulation assertion fires on crossing.

Test Plan:
- Port0 read, addr 0x1000, size 3, zero-wait slave -> req_ack[0] in cycle 0; m_araddr=0x1000, m_arlen=3, m_arid=0; 4 ret_data_valid[0] pulses with slave data; IDLE after rlast.
- Ports 0 and 1 request continuously -> grants alternate 0,1,0,1; m_arid/m_awid track the granted port.
- Port1 write 0x2004, data 0xDEADBEEF, be 4'b0110; awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles; m_wstrb=0110, m_wlast=1; bvalid -> IDLE.
- Read with rresp=SLVERR on beat 2 of 4 -> all 4 beats delivered; single bus_error[g] pulse after rlast; none on a following OKAY read.
- Write with bresp=DECERR -> bus_error pulse once; next request is granted normally.
- rst asserted during R after 2 of 8 beats -> next cycle all outputs 0, state IDLE, pointer 0; a fresh request is granted normally.

Source files
------------

// File: rtl/l1_axi_arbiter_bridge.sv
// Round-robin arbiter bridging NUM_PORTS L1 request channels onto one AXI4 master.
// One transaction in flight: INCR read bursts or single-beat strobed writes.
module l1_axi_arbiter_bridge #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int ID_W      = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_request,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data,
  input  logic [NUM_PORTS-1:0]        req_rnw,
  input  logic [NUM_PORTS*4-1:0]      req_be,
  input  logic [NUM_PORTS*5-1:0]      req_size,
  output logic [NUM_PORTS-1:0]        req_ack,
  output logic [DATA_W-1:0]           ret_data,
  output logic [NUM_PORTS-1:0]        ret_data_valid,
  output logic [NUM_PORTS-1:0]        bus_error,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  output logic [ADDR_W-1:0]           m_araddr,
  output logic [7:0]                  m_arlen,
  output logic [ID_W-1:0]             m_arid,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  input  logic [DATA_W-1:0]           m_rdata,
  input  logic [1:0]                  m_rresp,
  input  logic                        m_rlast,
  output logic                        m_awvalid,
  input  logic                        m_awready,
  output logic [ADDR_W-1:0]           m_awaddr,
  output logic [ID_W-1:0]             m_awid,
  output logic                        m_wvalid,
  input  logic                        m_wready,
  output logic [DATA_W-1:0]           m_wdata,
  output logic [DATA_W/8-1:0]         m_wstrb,
  output logic                        m_wlast,
  input  logic                        m_bvalid,
  output logic                        m_bready,
  input  logic [1:0]                  m_bresp
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} state_t;

  state_t                 state, state_nxt;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       gnt_idx;
  logic [PTR_W-1:0]       pick_idx;
  logic [PTR_W-1:0]       cand_idx;
  logic                   pick_vld;
  int                     cand;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      data_q;
  logic [3:0]             be_q;
  logic [7:0]             len_q;
  logic                   aw_done;
  logic                   w_done;
  logic                   err_flag;
  logic [NUM_PORTS-1:0]   bus_error_q;

  function automatic logic [7:0] clamp_len(input logic [4:0] size);
    if (int'(size) > MAX_BURST - 1) return 8'(MAX_BURST - 1);
    return {3'b000, size};
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    if (int'(idx) == NUM_PORTS - 1) return '0;
    return idx + 1'b1;
  endfunction

  // Scan from the highest offset down so the port closest to rr_ptr wins last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand     = (int'(rr_ptr) + i) % NUM_PORTS;
      cand_idx = PTR_W'(cand);
      if (req_request[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    req_ack        = '0;
    ret_data_valid = '0;
    m_arvalid      = 1'b0;
    m_rready       = 1'b0;
    m_awvalid      = 1'b0;
    m_wvalid       = 1'b0;
    m_bready       = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_vld && !rst) begin
          req_ack[pick_idx] = 1'b1;
          state_nxt         = req_rnw[pick_idx] ? S_AR : S_WR;
        end
      end
      S_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_nxt = S_R;
      end
      S_R: begin
        m_rready                = 1'b1;
        ret_data_valid[gnt_idx] = m_rvalid;
        if (m_rvalid && m_rlast) state_nxt = S_IDLE;
      end
      S_WR: begin
        m_awvalid = !aw_done;
        m_wvalid  = !w_done;
        if ((aw_done || m_awready) && (w_done || m_wready)) state_nxt = S_B;
      end
      S_B: begin
        m_bready = 1'b1;
        if (m_bvalid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant latch, handshake tracking, error capture and pointer advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      gnt_idx     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      be_q        <= '0;
      len_q       <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      err_flag    <= 1'b0;
      bus_error_q <= '0;
    end else begin
      bus_error_q <= '0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            gnt_idx  <= pick_idx;
            addr_q   <= {req_addr[int'(pick_idx)*ADDR_W+2 +: ADDR_W-2], 2'b00};
            data_q   <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
            be_q     <= req_be[int'(pick_idx)*4 +: 4];
            len_q    <= clamp_len(req_size[int'(pick_idx)*5 +: 5]);
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            err_flag <= 1'b0;
          end
        end
        S_R: begin
          if (m_rvalid) begin
            if (m_rlast) begin
              err_flag <= 1'b0;
              rr_ptr   <= next_ptr(gnt_idx);
              if (err_flag || (m_rresp != 2'b00)) bus_error_q[gnt_idx] <= 1'b1;
            end else if (m_rresp != 2'b00) begin
              err_flag <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (m_awready) aw_done <= 1'b1;
          if (m_wready)  w_done  <= 1'b1;
        end
        S_B: begin
          if (m_bvalid) begin
            rr_ptr <= next_ptr(gnt_idx);
            if (m_bresp != 2'b00) bus_error_q[gnt_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    m_arid                = '0;
    m_arid[PTR_W-1:0]     = gnt_idx;
    m_awid                = m_arid;
  end

  assign m_araddr  = addr_q;
  assign m_awaddr  = addr_q;
  assign m_arlen   = len_q;
  assign m_wdata   = data_q;
  assign m_wstrb   = be_q;
  assign m_wlast   = m_wvalid;
  assign ret_data  = m_rdata;
  assign bus_error = bus_error_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    assert (DATA_W == 32) else $error("DATA_W must be 32");
    assert (ID_W >= PTR_W) else $error("ID_W too narrow for NUM_PORTS");
    if (!rst && state == S_AR && m_arready)
      assert ((32'(addr_q[11:0]) + (32'(len_q) + 32'd1) * 32'd4) <= 32'd4096)
        else $error("read burst crosses a 4KB boundary");
  end
`endif

endmodule
